// File: rtl/wb_host_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_host_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // One-hot grant encodings as seen on gnt_o (bit0 = m0, bit1 = m1).
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  localparam int TO_W_DEF = 8;

  // Grant selection. On a tie m1 wins under priority mode; otherwise the
  // master that was not granted last wins.
  function automatic logic [1:0] arb_pick(input logic [1:0] req,
                                          input logic       pri_m1,
                                          input logic       last_m1);
    logic [1:0] g;
    g = GNT_NONE;
    case (req)
      2'b01:   g = GNT_M0;
      2'b10:   g = GNT_M1;
      2'b11:   g = (pri_m1 || !last_m1) ? GNT_M1 : GNT_M0;
      default: g = GNT_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/wb_arb_timeout.sv
// Bus watchdog: counts BUSY cycles without ack/err and flags expiry in the
// (2**TO_W-1)th such cycle, combinationally, so the arbiter can end the
// transfer in that same cycle.
module wb_arb_timeout
  import wb_host_arb_pkg::*;
#(
  parameter int TO_W = TO_W_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic busy_i,
  input  logic done_i,
  output logic expire_o
);

  // cnt_q holds the number of completed busy cycles, so the expiring cycle
  // is the one that starts with cnt_q == 2**TO_W-2.
  localparam logic [TO_W-1:0] CNT_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  logic [TO_W-1:0] cnt_q, cnt_d;

  assign expire_o = busy_i & ~done_i & (cnt_q == CNT_LAST);

  // Count busy cycles; any idle cycle, completion or expiry clears it, so
  // the count is always zero on entry to BUSY.
  always_comb begin
    cnt_d = cnt_q + TO_W'(1);
    if (!busy_i || done_i || expire_o) cnt_d = '0;
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/wb_host_arb.sv
// Two-master Wishbone arbiter (m0 = host, m1 = UART bridge) onto one slave.
// Registered grant held for the whole transfer, round-robin or m1-priority.
// Optional bus watchdog enabled by defining WB_HOST_ARB_TIMEOUT_EN.
module wb_host_arb
  import wb_host_arb_pkg::*;
#(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int TO_W = TO_W_DEF
) (
  input  logic            app_clk,
  input  logic            arst,
  input  logic            cfg_pri_mode,
  // master 0 (host)
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  // master 1 (UART bridge)
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  // slave
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  // status
  output logic [1:0]      gnt_o,
  output logic            timeout_o
);

  arb_state_e state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic       last_m1_q, last_m1_d;
  logic [1:0] req;
  logic       busy, sel_m1, cyc_g, stb_g, expire;

  // Per-master request fields packed so the slave mux is a simple index.
  logic [1:0]           cyc_a, stb_a, we_a;
  logic [1:0][AW-1:0]   adr_a;
  logic [1:0][DW-1:0]   dat_a;
  logic [1:0][DW/8-1:0] sel_a;

  assign cyc_a = {m1_cyc_i, m0_cyc_i};
  assign stb_a = {m1_stb_i, m0_stb_i};
  assign we_a  = {m1_we_i,  m0_we_i};
  assign adr_a = {m1_adr_i, m0_adr_i};
  assign dat_a = {m1_dat_i, m0_dat_i};
  assign sel_a = {m1_sel_i, m0_sel_i};

  assign req    = cyc_a & stb_a;
  assign busy   = (state_q == BUSY);
  assign sel_m1 = gnt_q[1];
  assign cyc_g  = cyc_a[sel_m1];
  assign stb_g  = stb_a[sel_m1];
  assign gnt_o  = gnt_q;

`ifdef WB_HOST_ARB_TIMEOUT_EN
  wb_arb_timeout #(.TO_W(TO_W)) u_timeout (
    .clk_i    (app_clk),
    .rst_i    (arst),
    .busy_i   (busy),
    .done_i   (s_ack_i | s_err_i),
    .expire_o (expire)
  );
  assign timeout_o = expire;
`else
  assign expire    = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // Next-state: arbitrate in IDLE, hold the grant in BUSY until ack, err,
  // master abort (cyc dropped) or watchdog expiry.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_m1_d = last_m1_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d     = arb_pick(req, cfg_pri_mode, last_m1_q);
          last_m1_d = gnt_d[1];
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (s_ack_i || s_err_i || !cyc_g || expire) begin
          gnt_d   = GNT_NONE;
          state_d = IDLE;
        end
      end
      default: begin
        gnt_d   = GNT_NONE;
        state_d = IDLE;
      end
    endcase
  end

  // State, grant and round-robin pointer; pointer starts at m1 so m0 wins
  // the first tie.
  always_ff @(posedge app_clk or posedge arst) begin
    if (arst) begin
      state_q   <= IDLE;
      gnt_q     <= GNT_NONE;
      last_m1_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_m1_q <= last_m1_d;
    end
  end

  // Slave-side mux: granted master's fields while BUSY, zero otherwise;
  // an expiring cycle already withdraws cyc/stb.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    if (busy) begin
      s_cyc_o = cyc_g & ~expire;
      s_stb_o = cyc_g & stb_g & ~expire;
      s_we_o  = we_a[sel_m1];
      s_adr_o = adr_a[sel_m1];
      s_dat_o = dat_a[sel_m1];
      s_sel_o = sel_a[sel_m1];
    end
  end

  // Master-side responses go only to the granted master (gnt_q is zero in
  // IDLE, which also drops stray acks). Expiry is reported as an error.
  always_comb begin
    m0_ack_o = gnt_q[0] & s_ack_i;
    m1_ack_o = gnt_q[1] & s_ack_i;
    m0_err_o = gnt_q[0] & (s_err_i | expire);
    m1_err_o = gnt_q[1] & (s_err_i | expire);
    m0_dat_o = gnt_q[0] ? s_dat_i : '0;
    m1_dat_o = gnt_q[1] ? s_dat_i : '0;
  end

endmodule

// File: tb/tb_wb_host_arb.sv
// Directed scoreboard bench for wb_host_arb (TO_W=4). The timeout step
// follows WB_HOST_ARB_TIMEOUT_EN the same way the design does.
module tb_wb_host_arb;

  logic        app_clk = 1'b0;
  logic        arst, cfg_pri_mode;
  logic        m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic        s_ack_i, s_err_i;
  logic [1:0]  gnt_o;
  logic        timeout_o;

  wb_host_arb #(.AW(32), .DW(32), .TO_W(4)) dut (
    .app_clk(app_clk), .arst(arst), .cfg_pri_mode(cfg_pri_mode),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_adr_i(m0_adr_i),
    .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_adr_i(m1_adr_i),
    .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .gnt_o(gnt_o), .timeout_o(timeout_o)
  );

  always #5 app_clk = ~app_clk;

  typedef struct {
    bit          m;
    logic [31:0] dat;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   k     = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit m, input logic [31:0] d, input logic e);
    exp_t x;
    x.m = m; x.dat = d; x.err = e;
    sb.push_back(x);
  endtask

  // Pops one expectation per ack/err seen on either master.
  task automatic mon();
    logic [1:0] r;
    exp_t       x;
    r = {m1_ack_o | m1_err_o, m0_ack_o | m0_err_o};
    if (r != 2'b00) begin
      if (sb.size() == 0) chk("unexpected_resp", 64'(r), 64'(0));
      else begin
        x = sb.pop_front();
        chk("resp_master", 64'(r), x.m ? 64'(2'b10) : 64'(2'b01));
        chk("resp_data", x.m ? 64'(m1_dat_o) : 64'(m0_dat_o), 64'(x.dat));
        chk("resp_err", x.m ? 64'(m1_err_o) : 64'(m0_err_o), 64'(x.err));
      end
    end
  endtask

  task automatic idle_inputs();
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0;
    s_dat_i = '0; s_ack_i = 0; s_err_i = 0;
  endtask

  task automatic do_reset();
    @(negedge app_clk);
    idle_inputs();
    arst = 1'b1;
    @(negedge app_clk);
    arst = 1'b0;
  endtask

  task automatic req0(input logic on);
    m0_cyc_i = on; m0_stb_i = on; m0_adr_i = 32'h1000_0000; m0_sel_i = 4'hF;
  endtask

  task automatic req1(input logic on);
    m1_cyc_i = on; m1_stb_i = on; m1_adr_i = 32'h2000_0000; m1_sel_i = 4'h3;
    m1_we_i = on; m1_dat_i = 32'h0BAD_F00D;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached limit 200000", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    cfg_pri_mode = 1'b0;
    idle_inputs();
    arst = 1'b1;
    #1;
    chk("rst_gnt", 64'(gnt_o), 64'(0));
    chk("rst_s_cyc", 64'(s_cyc_o), 64'(0));
    chk("rst_s_stb", 64'(s_stb_o), 64'(0));
    chk("rst_timeout", 64'(timeout_o), 64'(0));
    chk("rst_acks", 64'({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}), 64'(0));
    @(negedge app_clk);
    arst = 1'b0;

    // Stray ack/err in IDLE must be ignored.
    @(negedge app_clk);
    s_ack_i = 1; s_err_i = 1; s_dat_i = 32'h1234_5678;
    #1; mon();
    chk("stray_m0_dat", 64'(m0_dat_o), 64'(0));
    @(negedge app_clk);
    s_ack_i = 0; s_err_i = 0; s_dat_i = '0;
    #1; chk("stray_gnt", 64'(gnt_o), 64'(0));

    // Single read from m0, ack three cycles after grant.
    @(negedge app_clk);                        // cycle N
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h3000_0010; m0_sel_i = 4'hF;
    push(1'b0, 32'hDEAD_BEEF, 1'b0);
    #1; chk("rd_stb_N", 64'(s_stb_o), 64'(0));
    @(negedge app_clk);                        // N+1
    #1; chk("rd_stb_N1", 64'(s_stb_o), 64'(1));
    chk("rd_adr", 64'(s_adr_o), 64'(32'h3000_0010));
    chk("rd_we_sel", 64'({s_we_o, s_sel_o}), 64'(5'h0F));
    chk("rd_gnt", 64'(gnt_o), 64'(2'b01));
    mon();
    @(negedge app_clk);                        // N+2
    #1; mon();
    @(negedge app_clk);                        // N+3
    s_ack_i = 1; s_dat_i = 32'hDEAD_BEEF;
    #1; mon();
    @(negedge app_clk);
    idle_inputs();
    #1; chk("rd_done_gnt", 64'(gnt_o), 64'(0));

    // Round-robin with both masters requesting continuously.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge app_clk);
      req0(1); req1(1);
      #1;
      chk("rr_gnt", 64'(gnt_o), (c % 2 == 0) ? 64'(0) : ((c % 4 == 1) ? 64'(2'b01) : 64'(2'b10)));
      if (c % 4 == 3) chk("rr_m1_wdata", 64'({s_we_o, s_dat_o}), 64'({1'b1, 32'h0BAD_F00D}));
      if (c % 2 == 1) push(c % 4 == 3, 32'hC0DE_0000 + 32'(k), 1'b0);
      s_ack_i = s_stb_o;
      s_dat_i = s_stb_o ? 32'hC0DE_0000 + 32'(k) : '0;
      if (s_stb_o) k++;
      #1; mon();
    end
    @(negedge app_clk);
    idle_inputs();
    #1; chk("rr_end_gnt", 64'(gnt_o), 64'(0));

    // Priority mode: m1 wins every tie, m0 served only after m1 lets go.
    do_reset();
    cfg_pri_mode = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge app_clk);
      req0(1); req1(1);
      #1;
      chk("pri_gnt", 64'(gnt_o), (c % 2 == 0) ? 64'(0) : 64'(2'b10));
      if (c % 2 == 1) push(1'b1, 32'hD00D_0000 + 32'(k), 1'b0);
      s_ack_i = s_stb_o;
      s_dat_i = s_stb_o ? 32'hD00D_0000 + 32'(k) : '0;
      if (s_stb_o) k++;
      #1; mon();
    end
    @(negedge app_clk);
    req1(0); s_ack_i = 0; s_dat_i = '0;
    #1; chk("pri_idle", 64'(gnt_o), 64'(0));
    @(negedge app_clk);
    #1; chk("pri_m0_late", 64'(gnt_o), 64'(2'b01));
    push(1'b0, 32'h0000_00A5, 1'b0);
    s_ack_i = 1; s_dat_i = 32'h0000_00A5;
    #1; mon();
    @(negedge app_clk);
    idle_inputs();
    cfg_pri_mode = 1'b0;

    // Slave never answers m1; m0 waits behind it.
    do_reset();
    @(negedge app_clk);                        // cycle N
    req1(1);
`ifdef WB_HOST_ARB_TIMEOUT_EN
    push(1'b1, 32'h0, 1'b1);
    for (int i = 1; i <= 14; i++) begin
      @(negedge app_clk);
      req0(1);
      #1;
      chk("to_wait_gnt", 64'(gnt_o), 64'(2'b10));
      chk("to_wait_pulse", 64'(timeout_o), 64'(0));
      mon();
    end
    @(negedge app_clk);                        // N+15
    #1; mon();
    chk("to_pulse", 64'(timeout_o), 64'(1));
    chk("to_stb_low", 64'({s_cyc_o, s_stb_o}), 64'(0));
    @(negedge app_clk);                        // N+16
    req1(0);
    #1; chk("to_gnt_idle", 64'(gnt_o), 64'(0));
    chk("to_pulse_gone", 64'(timeout_o), 64'(0));
`else
    for (int i = 1; i <= 20; i++) begin
      @(negedge app_clk);
      req0(1);
      #1;
      chk("to_hold_gnt", 64'(gnt_o), 64'(2'b10));
      chk("to_tied_low", 64'(timeout_o), 64'(0));
      mon();
    end
    @(negedge app_clk);
    push(1'b1, 32'h5555_AAAA, 1'b0);
    s_ack_i = 1; s_dat_i = 32'h5555_AAAA;
    #1; mon();
    @(negedge app_clk);
    req1(0); s_ack_i = 0; s_dat_i = '0;
    #1; chk("to_gnt_idle", 64'(gnt_o), 64'(0));
`endif
    @(negedge app_clk);
    #1; chk("to_m0_next", 64'(gnt_o), 64'(2'b01));
    push(1'b0, 32'h1234_5678, 1'b0);
    s_ack_i = 1; s_dat_i = 32'h1234_5678;
    #1; mon();
    @(negedge app_clk);
    idle_inputs();

    // Abort: m1 drops cyc mid-transfer; no response to anyone.
    do_reset();
    @(negedge app_clk);                        // cycle N
    req1(1);
    @(negedge app_clk);                        // N+1
    req0(1);
    #1; chk("ab_gnt", 64'(gnt_o), 64'(2'b10));
    chk("ab_cyc", 64'(s_cyc_o), 64'(1));
    @(negedge app_clk);                        // N+2
    req1(0);
    #1; chk("ab_cyc_drop", 64'(s_cyc_o), 64'(0));
    mon();
    @(negedge app_clk);                        // N+3
    #1; chk("ab_idle", 64'(gnt_o), 64'(0));
    mon();
    @(negedge app_clk);                        // N+4
    #1; chk("ab_m0_gnt", 64'(gnt_o), 64'(2'b01));

    // Reset asserted mid-transfer, together with a slave ack.
    @(negedge app_clk);
    #1; chk("rm_stb_before", 64'(s_stb_o), 64'(1));
    s_ack_i = 1; s_dat_i = 32'hFACE_FACE;
    arst = 1'b1;
    #1;
    chk("rm_gnt", 64'(gnt_o), 64'(0));
    chk("rm_s_out", 64'({s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o}), 64'(0));
    chk("rm_m0_out", 64'({m0_ack_o, m0_err_o, m0_dat_o}), 64'(0));
    mon();
    @(negedge app_clk);
    idle_inputs();
    arst = 1'b0;

    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
